// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
// Shared constants for the ALU command sequencer:
//   - 3-bit operation codes accepted on cmd_op
//   - sequencer FSM state encoding (IDLE -> RD_A -> RD_B -> WB -> IDLE)
package alu_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD_A = 2'd1;
  localparam logic [1:0] ST_RD_B = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  // Shift amounts always come from the low five bits of operand B.
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_sequencer_alu_comb.sv
// alu_comb
// Purely combinational two-operand ALU: y = f(op, a, b).
// Ports:
//   op  in  3       operation code (see alu_sequencer_pkg)
//   a   in  DATA_W  operand A
//   b   in  DATA_W  operand B (shift amount is b[4:0])
//   y   out DATA_W  result, arithmetic wraps modulo 2^DATA_W
module alu_comb
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_signed;

  assign shamt     = b[SHAMT_W-1:0];
  assign lt_signed = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, lt_signed};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Accepts one two-operand ALU command at a time, reads both sources through
// the register file's single combinational read port on successive cycles,
// and writes the result back to the destination register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_rs1/rs2/rd      command fields
//   ridx / rdata               register file read index / read data
//   widx / wdata / we          register file write port
//   done                       one-cycle pulse during the writeback cycle
//   result / zero              last written result and its zero flag
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] ridx,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] widx,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [1:0]        state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [ADDR_W-1:0] rs2_q,    rs2_d;
  logic [ADDR_W-1:0] rd_q,     rd_d;
  logic [DATA_W-1:0] a_q,      a_d;
  logic [DATA_W-1:0] b_q,      b_d;
  logic [ADDR_W-1:0] ridx_q,   ridx_d;
  logic [ADDR_W-1:0] widx_q,   widx_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              we_q,     we_d;
  logic              done_q,   done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q,   zero_d;

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;

  // During RD_B operand B is still on rdata; feeding it straight into the
  // ALU lets wdata be registered at the end of RD_B, so the write port is
  // driven purely from flops throughout WB.
  assign alu_b = (state_q == ST_RD_B) ? rdata : b_q;

  alu_comb #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    ridx_d   = ridx_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rs2_d   = cmd_rs2;
          rd_d    = cmd_rd;
          // rs1 needs no holding register: ridx itself keeps it for RD_A.
          ridx_d  = cmd_rs1;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        a_d     = rdata;
        ridx_d  = rs2_q;
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        b_d     = rdata;
        widx_d  = rd_q;
        wdata_d = alu_y;
        we_d    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        result_d = wdata_q;
        zero_d   = (wdata_q == '0);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rs2_q    <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ridx_q   <= '0;
      widx_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ridx_q   <= ridx_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign ridx      = ridx_q;
  assign widx      = widx_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
